// File: rtl/mips_idex_stage.sv
// ID/EX pipeline register for the MIPS EX stage.
// Registers the decoded operands and control signals, and performs the
// ALUOp/funct -> ALUctl decode. It also forwards results from the EX/MEM and
// MEM/WB stages onto the ALU A/B inputs and the store-data path.
module mips_idex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic             id_branch,
    input  logic             exmem_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [WIDTH-1:0] exmem_aluout,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [3:0]       ALUctl,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ex_store_data,
    output logic [RADDR-1:0] ex_wreg,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_branch,
    output logic             ex_illegal
);

    typedef struct packed {
        logic             valid;
        logic [3:0]       aluctl;
        logic             illegal;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] wreg;
        logic             alusrc;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             branch;
    } ex_regs_t;

    ex_regs_t         ex_d, ex_q;
    logic [3:0]       dec_aluctl;
    logic             dec_illegal;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;

    // ALU-control decode from the ID-stage ALUOp and funct fields
    always_comb begin
        dec_aluctl  = 4'b0010;
        dec_illegal = 1'b0;
        case (id_aluop)
            2'b00: dec_aluctl = 4'b0010;
            2'b01: dec_aluctl = 4'b0110;
            2'b11: dec_aluctl = 4'b0001;
            default: begin
                case (id_funct)
                    6'b100000: dec_aluctl = 4'b0010;
                    6'b100010: dec_aluctl = 4'b0110;
                    6'b100100: dec_aluctl = 4'b0000;
                    6'b100101: dec_aluctl = 4'b0001;
                    6'b101010: dec_aluctl = 4'b0111;
                    6'b100111: dec_aluctl = 4'b1100;
                    default: begin
                        // Unknown R-type: execute as add and flag it
                        dec_aluctl  = 4'b0010;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Next register contents: flush beats stall; otherwise load unless stalled.
    // An invalid ID slot loads as a bubble, so its control never reaches EX.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid    = id_valid;
            ex_d.aluctl   = id_valid ? dec_aluctl : 4'b0000;
            ex_d.illegal  = id_valid & dec_illegal;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.wreg     = id_regdst ? id_rd : id_rt;
            ex_d.alusrc   = id_valid & id_alusrc;
            ex_d.regwrite = id_valid & id_regwrite;
            ex_d.memread  = id_valid & id_memread;
            ex_d.memwrite = id_valid & id_memwrite;
            ex_d.memtoreg = id_valid & id_memtoreg;
            ex_d.branch   = id_valid & id_branch;
        end
    end

    // Stage register; reset discards whatever is held, including a stalled op
    always_ff @(posedge clock) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs))
            fwd_rs = exmem_aluout;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs))
            fwd_rs = memwb_data;

        fwd_rt = ex_q.rt_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_q.rt))
            fwd_rt = exmem_aluout;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_q.rt))
            fwd_rt = memwb_data;
    end

    assign A             = fwd_rs;
    assign B             = ex_q.alusrc ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ALUctl        = ex_q.aluctl;
    assign ex_wreg       = ex_q.wreg;
    assign ex_valid      = ex_q.valid;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_memtoreg   = ex_q.memtoreg;
    assign ex_branch     = ex_q.branch;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_mips_idex_stage.sv
// Testbench for mips_idex_stage: a vector table plus hand-built sequences.
// Each applied stimulus pushes its expected EX contents onto a scoreboard,
// and the entry is popped and compared one cycle later.
module tb_mips_idex_stage;

    localparam int WIDTH = 32;
    localparam int RADDR = 5;

    logic             clock = 1'b0;
    logic             reset, stall, flush, id_valid;
    logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RADDR-1:0] id_rs, id_rt, id_rd;
    logic [1:0]       id_aluop;
    logic [5:0]       id_funct;
    logic             id_alusrc, id_regdst, id_regwrite, id_memread;
    logic             id_memwrite, id_memtoreg, id_branch;
    logic             exmem_regwrite, memwb_regwrite;
    logic [RADDR-1:0] exmem_rd, memwb_rd;
    logic [WIDTH-1:0] exmem_aluout, memwb_data;
    logic [3:0]       ALUctl;
    logic [WIDTH-1:0] A, B, ex_store_data;
    logic [RADDR-1:0] ex_wreg;
    logic             ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic             ex_memtoreg, ex_branch, ex_illegal;

    always #5 clock = ~clock;

    mips_idex_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg), .id_branch(id_branch),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_aluout(exmem_aluout),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .ALUctl(ALUctl), .A(A), .B(B), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch),
        .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic        reset, stall, flush, valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch;
        logic        xm_rw;
        logic [4:0]  xm_rd;
        logic [31:0] xm_out;
        logic        mw_rw;
        logic [4:0]  mw_rd;
        logic [31:0] mw_data;
    } stim_t;

    typedef struct {
        logic [3:0]  aluctl;
        logic [31:0] a, b, sd;
        logic [4:0]  wreg;
        logic        valid, rw, mr, mw, mtr, br, ill;
    } exp_t;

    // ctl_only: only the status/control fields are defined for this entry
    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
        logic  ctl_only;
    } vec_t;

    typedef struct {
        string name;
        exp_t  e;
        logic  ctl_only;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic stim_t base_stim();
        stim_t s;
        s = '{reset: 1'b0, stall: 1'b0, flush: 1'b0, valid: 1'b1,
              rs_data: 32'h0002_0054, rt_data: 32'h0000_0654, imm: 32'h0,
              rs: 5'd1, rt: 5'd2, rd: 5'd3, aluop: 2'b10, funct: 6'b100000,
              alusrc: 1'b0, regdst: 1'b1, regwrite: 1'b1, memread: 1'b0,
              memwrite: 1'b0, memtoreg: 1'b0, branch: 1'b0,
              xm_rw: 1'b0, xm_rd: 5'd0, xm_out: 32'h0,
              mw_rw: 1'b0, mw_rd: 5'd0, mw_data: 32'h0};
        return s;
    endfunction

    function automatic exp_t base_exp();
        exp_t e;
        e = '{aluctl: 4'b0010, a: 32'h0002_0054, b: 32'h0000_0654, sd: 32'h0000_0654,
              wreg: 5'd3, valid: 1'b1, rw: 1'b1, mr: 1'b0, mw: 1'b0, mtr: 1'b0,
              br: 1'b0, ill: 1'b0};
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{aluctl: 4'b0000, a: 32'h0, b: 32'h0, sd: 32'h0, wreg: 5'd0,
              valid: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, mtr: 1'b0, br: 1'b0, ill: 1'b0};
        return e;
    endfunction

    function automatic vec_t mk(string name, logic [5:0] funct, logic [3:0] ctl);
        vec_t v;
        v.name     = name;
        v.s        = base_stim();
        v.s.funct  = funct;
        v.e        = base_exp();
        v.e.aluctl = ctl;
        v.ctl_only = 1'b0;
        return v;
    endfunction

    task automatic drive(input stim_t s);
        reset          = s.reset;     stall       = s.stall;     flush       = s.flush;
        id_valid       = s.valid;     id_rs_data  = s.rs_data;   id_rt_data  = s.rt_data;
        id_imm         = s.imm;       id_rs       = s.rs;        id_rt       = s.rt;
        id_rd          = s.rd;        id_aluop    = s.aluop;     id_funct    = s.funct;
        id_alusrc      = s.alusrc;    id_regdst   = s.regdst;    id_regwrite = s.regwrite;
        id_memread     = s.memread;   id_memwrite = s.memwrite;  id_memtoreg = s.memtoreg;
        id_branch      = s.branch;
        exmem_regwrite = s.xm_rw;     exmem_rd    = s.xm_rd;     exmem_aluout = s.xm_out;
        memwb_regwrite = s.mw_rw;     memwb_rd    = s.mw_rd;     memwb_data   = s.mw_data;
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now
    task automatic check_pop();
        sb_t t;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        t = sbq.pop_front();
        chk(t.name, "ex_valid",    32'(ex_valid),    32'(t.e.valid));
        chk(t.name, "ex_regwrite", 32'(ex_regwrite), 32'(t.e.rw));
        chk(t.name, "ex_memread",  32'(ex_memread),  32'(t.e.mr));
        chk(t.name, "ex_memwrite", 32'(ex_memwrite), 32'(t.e.mw));
        chk(t.name, "ex_memtoreg", 32'(ex_memtoreg), 32'(t.e.mtr));
        chk(t.name, "ex_branch",   32'(ex_branch),   32'(t.e.br));
        chk(t.name, "ex_illegal",  32'(ex_illegal),  32'(t.e.ill));
        if (!t.ctl_only) begin
            chk(t.name, "ALUctl",        32'(ALUctl),  32'(t.e.aluctl));
            chk(t.name, "A",             A,             t.e.a);
            chk(t.name, "B",             B,             t.e.b);
            chk(t.name, "ex_store_data", ex_store_data, t.e.sd);
            chk(t.name, "ex_wreg",       32'(ex_wreg), 32'(t.e.wreg));
        end
    endtask

    // Drive one cycle of stimulus, then check one cycle later on the falling edge
    task automatic apply(input vec_t v);
        drive(v.s);
        sbq.push_back('{name: v.name, e: v.e, ctl_only: v.ctl_only});
        @(posedge clock);
        @(negedge clock);
        check_pop();
    endtask

    initial begin
        vec_t v, x;

        // Reset held two cycles with a live R-type on the ID inputs
        for (int i = 0; i < 2; i++) begin
            v = mk("reset", 6'b100000, 4'b0000);
            v.s.reset = 1'b1;
            v.e = zero_exp();
            apply(v);
        end

        // Table of single-cycle vectors
        tbl.push_back(mk("r_add", 6'b100000, 4'b0010));
        tbl.push_back(mk("r_sub", 6'b100010, 4'b0110));
        tbl.push_back(mk("r_and", 6'b100100, 4'b0000));
        tbl.push_back(mk("r_or",  6'b100101, 4'b0001));
        tbl.push_back(mk("r_slt", 6'b101010, 4'b0111));
        tbl.push_back(mk("r_nor", 6'b100111, 4'b1100));
        v = mk("r_illegal", 6'b000000, 4'b0010); v.e.ill = 1'b1; tbl.push_back(v);

        v = mk("imm_lw", 6'b000000, 4'b0010);
        v.s.aluop = 2'b00; v.s.alusrc = 1'b1; v.s.imm = 32'hFFFF_FFFC;
        v.s.regdst = 1'b0; v.s.memread = 1'b1; v.s.memtoreg = 1'b1;
        v.e.b = 32'hFFFF_FFFC; v.e.wreg = 5'd2; v.e.mr = 1'b1; v.e.mtr = 1'b1;
        tbl.push_back(v);

        v = mk("imm_sw", 6'b111111, 4'b0010);
        v.s.aluop = 2'b00; v.s.alusrc = 1'b1; v.s.imm = 32'h0000_0010;
        v.s.regwrite = 1'b0; v.s.memwrite = 1'b1;
        v.e.b = 32'h0000_0010; v.e.rw = 1'b0; v.e.mw = 1'b1;
        tbl.push_back(v);

        v = mk("beq", 6'b100101, 4'b0110);
        v.s.aluop = 2'b01; v.s.regwrite = 1'b0; v.s.branch = 1'b1;
        v.e.rw = 1'b0; v.e.br = 1'b1;
        tbl.push_back(v);

        v = mk("ori", 6'b100010, 4'b0001);
        v.s.aluop = 2'b11; v.s.alusrc = 1'b1; v.s.imm = 32'h0000_00FF; v.s.regdst = 1'b0;
        v.e.b = 32'h0000_00FF; v.e.wreg = 5'd2;
        tbl.push_back(v);

        v = mk("fwd_exmem_prio", 6'b100000, 4'b0010);
        v.s.rs = 5'd5;
        v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd5; v.s.xm_out = 32'h0000_AAAA;
        v.s.mw_rw = 1'b1; v.s.mw_rd = 5'd5; v.s.mw_data = 32'h0000_BBBB;
        v.e.a = 32'h0000_AAAA;
        tbl.push_back(v);

        v.name = "fwd_memwb"; v.s.xm_rw = 1'b0; v.e.a = 32'h0000_BBBB;
        tbl.push_back(v);

        v.name = "fwd_rd_zero"; v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd0; v.s.mw_rd = 5'd0;
        v.e.a = 32'h0002_0054;
        tbl.push_back(v);

        v = mk("fwd_reg0", 6'b100000, 4'b0010);
        v.s.rs = 5'd0; v.s.rt = 5'd0;
        v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd0; v.s.xm_out = 32'hDEAD_BEEF;
        v.s.mw_rw = 1'b1; v.s.mw_rd = 5'd0; v.s.mw_data = 32'hCAFE_F00D;
        tbl.push_back(v);

        v = mk("fwd_rt_memwb", 6'b100000, 4'b0010);
        v.s.rt = 5'd7; v.s.mw_rw = 1'b1; v.s.mw_rd = 5'd7; v.s.mw_data = 32'h0000_CCCC;
        v.e.b = 32'h0000_CCCC; v.e.sd = 32'h0000_CCCC;
        tbl.push_back(v);

        v.name = "fwd_rt_alusrc"; v.s.aluop = 2'b00; v.s.alusrc = 1'b1;
        v.s.imm = 32'h0000_0020; v.s.mw_rd = 5'd9;
        v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd7; v.s.xm_out = 32'h0000_DDDD;
        v.e.b = 32'h0000_0020; v.e.sd = 32'h0000_DDDD;
        tbl.push_back(v);

        v = mk("bubble", 6'b000000, 4'b0000);
        v.s.valid = 1'b0; v.s.memwrite = 1'b1; v.s.memread = 1'b1; v.s.branch = 1'b1;
        v.e = zero_exp(); v.ctl_only = 1'b1;
        tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Stall: load an OR, then hold it while the ID inputs change
        x = mk("stall_load", 6'b100101, 4'b0001);
        apply(x);
        for (int i = 0; i < 3; i++) begin
            v = x;
            v.name = "stall_hold";
            v.s.stall = 1'b1; v.s.funct = 6'b100010; v.s.rs_data = 32'h1111_1111;
            v.s.rt_data = 32'h2222_2222; v.s.rs = 5'd9; v.s.rd = 5'd9;
            v.s.memwrite = 1'b1; v.s.regwrite = (i == 1);
            apply(v);
        end
        // Forwarding still follows the live EX/MEM inputs while stalled
        v = x;
        v.name = "stall_fwd";
        v.s.stall = 1'b1; v.s.funct = 6'b100111;
        v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd1; v.s.xm_out = 32'h1234_5678;
        v.e.a = 32'h1234_5678;
        apply(v);
        // Flush wins over stall; r0 in the bubble must not pick up EX/MEM data
        v = x;
        v.name = "stall_flush";
        v.s.stall = 1'b1; v.s.flush = 1'b1;
        v.s.xm_rw = 1'b1; v.s.xm_rd = 5'd0; v.s.xm_out = 32'hDEAD_BEEF;
        v.e = zero_exp();
        apply(v);

        // Reset during a stall discards the held instruction
        x = mk("rst_load", 6'b101010, 4'b0111);
        x.s.memtoreg = 1'b1; x.e.mtr = 1'b1;
        apply(x);
        v = x;
        v.name = "rst_in_stall";
        v.s.stall = 1'b1; v.s.reset = 1'b1;
        v.e = zero_exp();
        apply(v);

        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
